// File: rtl/vec_csr_pkg.sv
// Shared types and helpers for the vector CSR unit: vtype layout, CSR map,
// Zicsr funct3 encodings and the shift-only VLMAX function.
package vec_csr_pkg;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        SEW_8  = 3'b000,
        SEW_16 = 3'b001,
        SEW_32 = 3'b010,
        SEW_64 = 3'b011
    } vew_e;

    typedef enum logic [11:0] {
        CSR_VSTART = 12'h008,
        CSR_VXSAT  = 12'h009,
        CSR_VXRM   = 12'h00A,
        CSR_VCSR   = 12'h00F,
        CSR_VL     = 12'hC20,
        CSR_VTYPE  = 12'hC21,
        CSR_VLENB  = 12'hC22
    } csr_addr_e;

    // Field order matches the architectural vtype bits [7:0]; vill sits on top.
    typedef struct packed {
        logic   vill;
        logic   vma;
        logic   vta;
        vew_e   vsew;
        vlmul_e vlmul;
    } csr_vtype_s;

    localparam csr_vtype_s VTYPE_ILL = '{vill: 1'b1, vma: 1'b0, vta: 1'b0,
                                         vsew: SEW_8, vlmul: LMUL_1};

    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Low two funct3 bits select the operation for both register and imm forms.
    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    function automatic logic [31:0] vlmax_calc(input logic [2:0] vsew,
                                               input logic [2:0] vlmul,
                                               input int unsigned vlen);
        int unsigned base;
        base = vlen >> (32'(vsew) + 32'd3);
        if (vlmul[2])
            return base >> (32'd4 - 32'(vlmul[1:0]));
        else
            return base << vlmul[1:0];
    endfunction

endpackage

// File: rtl/vec_csr_unit_if.sv
// Core-facing bus of the vector CSR unit: vset* request channel and Zicsr channel.
interface vec_csr_unit_if #(
    parameter int XLEN = 32
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [XLEN-1:0] cfg_avl;
    logic [XLEN-1:0] cfg_vtype;
    logic            cfg_rs1_x0;
    logic            cfg_rd_x0;
    logic            cfg_imm_avl;
    logic            cfg_done;
    logic [XLEN-1:0] cfg_rd_data;

    logic            csr_valid;
    logic            csr_ready;
    logic [XLEN-1:0] csr_inst;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_rsp_valid;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output cfg_valid, cfg_avl, cfg_vtype, cfg_rs1_x0, cfg_rd_x0, cfg_imm_avl,
        input  cfg_ready, cfg_done, cfg_rd_data,
        output csr_valid, csr_inst, csr_wdata,
        input  csr_ready, csr_rsp_valid, csr_rdata, csr_illegal
    );

    modport slave (
        input  cfg_valid, cfg_avl, cfg_vtype, cfg_rs1_x0, cfg_rd_x0, cfg_imm_avl,
        output cfg_ready, cfg_done, cfg_rd_data,
        input  csr_valid, csr_inst, csr_wdata,
        output csr_ready, csr_rsp_valid, csr_rdata, csr_illegal
    );
endinterface

// File: rtl/vec_vl_calc.sv
// Combinational vset* evaluation: vtype legality, VLMAX and the new vl.
module vec_vl_calc
    import vec_csr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 128,
    parameter int ELEN = 64,
    parameter int VLW  = $clog2(VLEN) + 1
) (
    input  logic [XLEN-2:0] vtype_req,
    input  logic [XLEN-1:0] avl,
    input  logic            rs1_x0,
    input  logic            rd_x0,
    input  logic            imm_avl,
    input  logic [VLW-1:0]  cur_vl,
    output logic            ill,
    output logic [VLW-1:0]  vlmax,
    output logic [VLW-1:0]  vl_new,
    output csr_vtype_s      vtype_new
);
    logic [2:0]      vsew;
    logic [2:0]      vlmul;
    logic [63:0]     legal_tab;
    logic [XLEN-1:0] vlmax_x;
    logic [VLW-1:0]  vlmax_n;
    logic            keep_vl;
    logic            to_max;
    logic            shrink;
    logic [VLW-1:0]  vl_pick;

    assign vsew  = vtype_req[5:3];
    assign vlmul = vtype_req[2:0];

    // Legality of every {vsew, vlmul} pair is fixed by ELEN, so tabulate it.
    for (genvar gi = 0; gi < 64; gi++) begin : g_legal
        localparam int SC = gi / 8;
        localparam int LC = gi % 8;
        assign legal_tab[gi] = (SC < 4) && ((8 << SC) <= ELEN) && (LC != 4) &&
                               ((LC < 4) || ((8 << SC) <= (ELEN >> (8 - LC))));
    end

    assign vlmax_x = XLEN'(vlmax_calc(vsew, vlmul, VLEN));
    assign vlmax_n = vlmax_x[VLW-1:0];

    assign keep_vl = !imm_avl && rs1_x0 && rd_x0;
    assign to_max  = !imm_avl && rs1_x0 && !rd_x0;
    assign shrink  = keep_vl && (vlmax_x < XLEN'(cur_vl));

    assign ill = (|vtype_req[XLEN-2:8]) || !legal_tab[{vsew, vlmul}] || shrink;

    always_comb begin
        if (keep_vl)
            vl_pick = cur_vl;
        else if (to_max)
            vl_pick = vlmax_n;
        else if (avl < vlmax_x)
            vl_pick = avl[VLW-1:0];
        else
            vl_pick = vlmax_n;
    end

    assign vl_new = ill ? '0 : vl_pick;
    assign vlmax  = ill ? '0 : vlmax_n;

    assign vtype_new = ill ? VTYPE_ILL :
                       '{vill: 1'b0, vma: vtype_req[7], vta: vtype_req[6],
                         vsew: vew_e'(vsew), vlmul: vlmul_e'(vlmul)};
endmodule

// File: rtl/vec_csr_unit.sv
// Vector CSR unit: vset* sequencer (IDLE/CALC/COMMIT) plus the Zicsr port for
// vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb with a registered response.
module vec_csr_unit
    import vec_csr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 128,
    parameter int ELEN = 64,
    parameter int VLW  = $clog2(VLEN) + 1
) (
    input  logic           clk,
    input  logic           n_rst,
    vec_csr_unit_if.slave  bus,
    input  logic           vec_done,
    input  logic           vxsat_set,
    output logic [6:0]     sew,
    output logic [2:0]     lmul_code,
    output logic [VLW-1:0] vlmax,
    output logic [VLW-1:0] vl,
    output logic [VLW-1:0] vstart,
    output logic           vta,
    output logic           vma,
    output logic           vill,
    output logic [1:0]     vxrm
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]      state_reg, state_next;

    logic [XLEN-1:0] req_avl_reg;
    logic [XLEN-2:0] req_vtype_reg;
    logic            req_rs1_x0_reg, req_rd_x0_reg, req_imm_reg;

    logic            calc_ill;
    logic [VLW-1:0]  calc_vlmax, calc_vl;
    csr_vtype_s      calc_vtype;
    logic [VLW-1:0]  calc_vlmax_reg, calc_vl_reg;
    csr_vtype_s      calc_vtype_reg;

    csr_vtype_s      vtype_reg;
    logic [VLW-1:0]  vl_reg, vlmax_reg, vstart_reg;
    logic [1:0]      vxrm_reg;
    logic            vxsat_reg;

    logic            rsp_valid_reg, rsp_illegal_reg;
    logic [XLEN-1:0] rsp_rdata_reg;

    logic [6:0]      csr_opcode;
    logic [2:0]      csr_f3;
    logic [4:0]      csr_src_idx;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_old, csr_src, csr_wval;
    logic            csr_known, csr_ro, csr_wr_req, csr_bad, csr_accept, csr_do_wr;
    logic            wr_vstart, wr_vxsat, wr_vxrm, wr_vcsr;
    logic            unused_bits;

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:   state_next = bus.cfg_valid ? ST_CALC : ST_IDLE;
            ST_CALC:   state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    vec_vl_calc #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN), .VLW(VLW)) u_vl_calc (
        .vtype_req (req_vtype_reg),
        .avl       (req_avl_reg),
        .rs1_x0    (req_rs1_x0_reg),
        .rd_x0     (req_rd_x0_reg),
        .imm_avl   (req_imm_reg),
        .cur_vl    (vl_reg),
        .ill       (calc_ill),
        .vlmax     (calc_vlmax),
        .vl_new    (calc_vl),
        .vtype_new (calc_vtype)
    );

    assign csr_opcode  = bus.csr_inst[6:0];
    assign csr_f3      = bus.csr_inst[14:12];
    assign csr_src_idx = bus.csr_inst[19:15];
    assign csr_addr    = bus.csr_inst[31:20];

    always_comb begin
        csr_old   = '0;
        csr_known = 1'b1;
        csr_ro    = 1'b0;
        case (csr_addr)
            CSR_VSTART: csr_old = XLEN'(vstart_reg);
            CSR_VXSAT:  csr_old = XLEN'(vxsat_reg);
            CSR_VXRM:   csr_old = XLEN'(vxrm_reg);
            CSR_VCSR:   csr_old = XLEN'({vxrm_reg, vxsat_reg});
            CSR_VL:     begin csr_old = XLEN'(vl_reg); csr_ro = 1'b1; end
            CSR_VTYPE:  begin
                csr_old = {vtype_reg.vill, {(XLEN-9){1'b0}}, vtype_reg[7:0]};
                csr_ro  = 1'b1;
            end
            CSR_VLENB:  begin csr_old = XLEN'(VLEN / 8); csr_ro = 1'b1; end
            default:    csr_known = 1'b0;
        endcase
    end

    // Set/clear with a zero source field is a pure read and may target read-only CSRs.
    assign csr_src    = csr_f3[2] ? XLEN'(csr_src_idx) : bus.csr_wdata;
    assign csr_wr_req = (csr_f3[1:0] == CSR_OP_RW) || (csr_src_idx != 5'd0);

    always_comb begin
        case (csr_f3[1:0])
            CSR_OP_RW: csr_wval = csr_src;
            CSR_OP_RS: csr_wval = csr_old | csr_src;
            CSR_OP_RC: csr_wval = csr_old & ~csr_src;
            default:   csr_wval = csr_old;
        endcase
    end

    assign csr_bad = (csr_opcode != OPC_SYSTEM) || (csr_f3[1:0] == 2'b00) ||
                     !csr_known || (csr_ro && csr_wr_req);

    assign bus.csr_ready = (state_reg == ST_IDLE) && !bus.cfg_valid;
    assign csr_accept    = bus.csr_valid && bus.csr_ready;
    assign csr_do_wr     = csr_accept && !csr_bad && csr_wr_req;

    assign wr_vstart = csr_do_wr && (csr_addr == CSR_VSTART);
    assign wr_vxsat  = csr_do_wr && (csr_addr == CSR_VXSAT);
    assign wr_vxrm   = csr_do_wr && (csr_addr == CSR_VXRM);
    assign wr_vcsr   = csr_do_wr && (csr_addr == CSR_VCSR);

    assign unused_bits = ^{bus.csr_inst[11:7], csr_wval[XLEN-1:VLW]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= ST_IDLE;
            req_avl_reg    <= '0;
            req_vtype_reg  <= '0;
            req_rs1_x0_reg <= 1'b0;
            req_rd_x0_reg  <= 1'b0;
            req_imm_reg    <= 1'b0;
            calc_vlmax_reg <= '0;
            calc_vl_reg    <= '0;
            calc_vtype_reg <= VTYPE_ILL;
            vtype_reg      <= VTYPE_ILL;
            vl_reg         <= '0;
            vlmax_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && bus.cfg_valid) begin
                req_avl_reg    <= bus.cfg_avl;
                req_vtype_reg  <= bus.cfg_vtype[XLEN-2:0];
                req_rs1_x0_reg <= bus.cfg_rs1_x0;
                req_rd_x0_reg  <= bus.cfg_rd_x0;
                req_imm_reg    <= bus.cfg_imm_avl;
            end
            if (state_reg == ST_CALC) begin
                calc_vlmax_reg <= calc_vlmax;
                calc_vl_reg    <= calc_vl;
                calc_vtype_reg <= calc_vtype;
            end
            if (state_reg == ST_COMMIT) begin
                vtype_reg <= calc_vtype_reg;
                vl_reg    <= calc_vl_reg;
                vlmax_reg <= calc_vlmax_reg;
            end
        end
    end

    // A CSR write beats the lane-side side effects landing in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vstart_reg      <= '0;
            vxsat_reg       <= 1'b0;
            vxrm_reg        <= 2'd0;
            rsp_valid_reg   <= 1'b0;
            rsp_illegal_reg <= 1'b0;
            rsp_rdata_reg   <= '0;
        end else begin
            if (state_reg == ST_COMMIT)
                vstart_reg <= '0;
            else if (wr_vstart)
                vstart_reg <= csr_wval[VLW-1:0];
            else if (vec_done)
                vstart_reg <= '0;

            if (wr_vxsat || wr_vcsr)
                vxsat_reg <= csr_wval[0];
            else if (vxsat_set)
                vxsat_reg <= 1'b1;

            if (wr_vxrm)
                vxrm_reg <= csr_wval[1:0];
            else if (wr_vcsr)
                vxrm_reg <= csr_wval[2:1];

            rsp_valid_reg   <= csr_accept;
            rsp_illegal_reg <= csr_accept && csr_bad;
            rsp_rdata_reg   <= (csr_accept && !csr_bad) ? csr_old : '0;
        end
    end

    assign bus.cfg_ready     = (state_reg == ST_IDLE);
    assign bus.cfg_done      = (state_reg == ST_COMMIT);
    assign bus.cfg_rd_data   = (state_reg == ST_COMMIT) ? XLEN'(calc_vl_reg) : '0;
    assign bus.csr_rsp_valid = rsp_valid_reg;
    assign bus.csr_rdata     = rsp_rdata_reg;
    assign bus.csr_illegal   = rsp_illegal_reg;

    assign sew       = 7'd8 << vtype_reg.vsew;
    assign lmul_code = vtype_reg.vlmul;
    assign vta       = vtype_reg.vta;
    assign vma       = vtype_reg.vma;
    assign vill      = vtype_reg.vill;
    assign vl        = vl_reg;
    assign vlmax     = vlmax_reg;
    assign vstart    = vstart_reg;
    assign vxrm      = vxrm_reg;
endmodule

// File: doc/vec_csr_unit.md
Name: vec_csr_unit

Overview:
- Parametrised vector CSR unit: owns vtype, vl, vstart, vxrm, vxsat, vcsr (alias) and vlenb.
- Executes vsetvli/vsetivli/vsetvl with full RVV 1.0 vl/vill rules, including fractional LMUL.
- Serves Zicsr accesses from the scalar core over a valid/ready port with a registered response.
- Sits between vec_decode and the scalar core; decoded vtype fields feed the lanes and load/store units.

Parameters:
- XLEN, 32, scalar register / CSR width.
- VLEN, 128, vector register bits; power of two, 64..4096.
- ELEN, 64, maximum supported SEW (32 or 64).
- VLW, $clog2(VLEN)+1, width of vl/vlmax (max VLMAX = VLEN at e8 m8 / 8).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- cfg_valid  in  1  vset* request
- cfg_ready  out  1  unit can accept cfg
- cfg_avl  in  XLEN  AVL (rs1 value, or uimm for vsetivli)
- cfg_vtype  in  XLEN  requested vtype (zimm or rs2 value)
- cfg_rs1_x0  in  1  rs1 field is x0 (ignored for vsetivli)
- cfg_rd_x0  in  1  rd field is x0
- cfg_imm_avl  in  1  vsetivli form
- cfg_done  out  1  one-cycle pulse, new vl/vtype committed
- cfg_rd_data  out  XLEN  new vl, zero-extended, for rd writeback
- csr_valid  in  1  CSR access request
- csr_ready  out  1  CSR request accepted this cycle
- csr_inst  in  XLEN  full SYSTEM instruction
- csr_wdata  in  XLEN  rs1 value
- csr_rsp_valid  out  1  response pulse
- csr_rdata  out  XLEN  old CSR value
- csr_illegal  out  1  illegal access (with csr_rsp_valid)
- vec_done  in  1  vector instruction retired (clears vstart)
- vxsat_set  in  1  saturation occurred in a lane
- sew  out  7  8/16/32/64
- lmul_code  out  3  raw vlmul
- vlmax  out  VLW  current VLMAX
- vl  out  VLW  current vl
- vstart  out  VLW  current vstart
- vta, vma, vill  out  1 each  vtype flags
- vxrm  out  2  rounding mode

Behaviour:
- Reset values: vill=1; other vtype fields 0; vl=0; vstart=0; vxrm=0; vxsat=0. FSM in IDLE. All pulses 0.
- FSM states: IDLE, CALC, COMMIT.
  - cfg_ready=1 only in IDLE.
  - IDLE & cfg_valid: latch request -> CALC.
  - CALC: decode SEW/LMUL, check legality, compute VLMAX into a register -> COMMIT.
  - COMMIT: write vtype/vl, pulse cfg_done -> IDLE.
  - Latency: accept to cfg_done is 2 cycles; back-to-back accept on the cycle after cfg_done.
- vill is set when any of these holds:
  - vtype[XLEN-2:8] != 0
  - vsew > 3, or SEW > ELEN
  - vlmul == 3'b100
  - fractional LMUL (101=1/8, 110=1/4, 111=1/2) with SEW > ELEN*LMUL
- On vill: vtype = {1, 0...}; vl = 0; cfg_rd_data = 0.
- VLMAX = (VLEN/SEW)*LMUL, or (VLEN/SEW)>>k for fractional LMUL. Compute with shifts, no divider.
- vl rules:
  - vsetivli, or rs1 != x0: vl = min(AVL, VLMAX). Compare at full XLEN width.
  - rs1 == x0, rd != x0: vl = VLMAX.
  - rs1 == x0, rd == x0: vl unchanged. If the new VLMAX < old vl, set vill as above.
- Every committed vset* clears vstart to 0.
- CSR accesses:
  - csr_ready = (state==IDLE) & !cfg_valid; cfg has priority.
  - Response is registered, 1 cycle after accept.
  - funct3 001/010/011 use csr_wdata; 101/110/111 use zimm = inst[19:15].
  - Writable CSRs: vstart 0x008 (low VLW bits stored), vxsat 0x009 (bit 0), vxrm 0x00A (bits 1:0), vcsr 0x00F (vxrm at [2:1], vxsat at [0]).
  - Read-only CSRs: vl 0xC20, vtype 0xC21 (vill at XLEN-1), vlenb 0xC22 (=VLEN/8).
  - RS/RC with rs1/zimm == 0 performs no write.
- Illegal accesses: any write to a read-only CSR, an unknown address, opcode != 7'h73, or funct3 000/100.
  - Response: csr_illegal=1, csr_rdata=0, no state change.
- Same-cycle conflicts:
  - CSR write to vstart and vec_done: the CSR write wins.
  - vxsat_set with a CSR write of vxsat/vcsr: the CSR write wins.
  - Otherwise vxsat |= vxsat_set (sticky).
- Reset mid-operation: FSM returns to IDLE, the pending request is dropped, no cfg_done.

Decomposition:
- vec_csr_pkg holds:
  - csr_vtype_s, vlmul_e, vew_e, csr_addr_e (incl. VXSAT/VXRM/VCSR/VLENB)
  - funct3 encodings, SYSTEM opcode
  - function vlmax_calc(vsew, vlmul, VLEN)
- Sub-module vec_vl_calc (combinational, instantiated once): legality check, VLMAX, min(AVL, VLMAX).

Test Plan (VLEN=128, ELEN=64):
- Reset release -> vill=1, vl=0, vstart=0; csrrs vtype with rs1=x0 -> csr_rdata=0x8000_0000, csr_illegal=0.
- vsetvli avl=100, e32 m2 -> cfg_done 2 cycles after accept, vlmax=8, vl=8, cfg_rd_data=8; then avl=5 -> vl=5.
- vsetvli rs1=x0, rd=x3, e8 mf2 -> vl=8; then e64 mf2 -> vill=1, vl=0, cfg_rd_data=0.
- csrrs vl with rs1=x5 -> csr_illegal=1, vl unchanged; csrrs vlenb with rs1=x0 -> csr_rdata=16.
- csrrw vstart=7 in the same cycle as vec_done -> vstart=7; next vec_done alone -> vstart=0.
- vxsat_set pulse, then csrrs vcsr with rs1=x0 -> csr_rdata=1; csrrwi vxrm zimm=2 -> vxrm=2, vcsr reads 0x5.
